drv_spi_slave_mc: RTL
=====================

// Module: drv_spi_slave_mc
// PURPOSE
//  Parametrised SPI slave, multi-channel successor of the fixed-mode cmd/data SPI driver.
//  Supports any mode (CPOL/CPHA, runtime), N chip selects, configurable word width, continuous multi-word bursts.
//  Provides per-word rx/tx handshakes and abort/error reporting.
//  Sits between the MCU SPI pins (async to clk) and the register/datapath logic in the clk domain.
// PARAMETERS
//  WIDTH   16  bits per word, 4..32
//  N_CS    2   number of active-low chip selects (channels), 1..8
//  CH_W    3   channel index width, >= clog2(N_CS), min 1
//  MSB_1ST 1   1: MSB first on sdi/sdo; 0: LSB first
// PORTS
//  clk          in   1      system clock; must be >= 8x spi_scl
//  rst_n        in   1      async active-low reset
//  spi_scl      in   1      SPI clock from master (async)
//  spi_sdi      in   1      master-out data (async)
//  spi_sdo      out  1      slave-out data
//  spi_cs_n     in   N_CS   chip selects, active low (async)
//  cfg_mode     in   2      {CPOL,CPHA}; captured only while all spi_cs_n high
//  tx_data      in   WIDTH  next word to transmit
//  tx_ready     out  1      1-clk pulse: tx_data captured, next word may be presented
//  rx_data      out  WIDTH  last complete received word
//  rx_valid     out  1      1-clk pulse: rx_data updated
//  rx_ch        out  CH_W   channel index of current/last frame
//  frame_start  out  1      1-clk pulse at frame start
//  frame_end    out  1      1-clk pulse at frame end (CS deassert)
//  abort        out  1      1-clk pulse: frame ended with partial word (bit_cnt != 0)
//  cs_err       out  1      1-clk pulse: >1 CS asserted simultaneously
// BEHAVIOUR
//  Reset: spi_sdo=0, tx_ready=0, rx_data=0, rx_valid=0, rx_ch=0, frame_start=0, frame_end=0, abort=0, cs_err=0.
//   Internal: state IDLE, bit_cnt=0, mode_r=0.
//  Sync: spi_scl, spi_sdi, spi_cs_n via 2-FF synchronisers + 1 history flop; edges from synchronised signals.
//  sel = exactly one CS low; any = at least one CS low; chan = index of the low CS.
//  States:
//   IDLE: mode_r<=cfg_mode each clk. any & !sel -> cs_err pulse, goto ERR.
//    sel -> frame_start pulse, rx_ch<=chan, bit_cnt<=0, tx shreg<=tx_data, tx_ready pulse, goto ACTIVE.
//    If CPHA=0, spi_sdo <= first bit of tx_data in the same clk.
//   ACTIVE: lead = first clock edge after idle level CPOL (rise if CPOL=0); trail = opposite edge.
//    Sample edge = lead if CPHA=0, trail if CPHA=1; shift edge = the other one.
//    Sample edge: shift sdi into rx shreg, bit_cnt++.
//     On bit WIDTH: rx_data<=assembled word, rx_valid pulse next clk, bit_cnt<=0.
//     Same clk: tx shreg<=tx_data, tx_ready pulse.
//    Shift edge: spi_sdo <= next tx bit.
//     CPHA=1: first shift edge of each word drives bit 0 of that word (no advance).
//     CPHA=0: shift edge after a word boundary drives bit 0 of the reloaded word.
//    !sel (all CS high, or selected CS changes, or 2nd CS drops):
//     frame_end pulse; abort pulse if bit_cnt!=0 (partial word discarded, no rx_valid).
//     Goto IDLE, or ERR if any CS still low.
//   ERR: spi_sdo held 0, no shifting; goto IDLE when all CS high (no pulses).
//  Simultaneous sample edge completing word and CS deassert in same clk:
//   word is complete -> rx_valid, no abort.
//  spi_sdo = 0 whenever state != ACTIVE. cfg_mode changes during a frame are ignored.
//  Latency: rx_valid 4 clk after the synchronised sample edge of the last bit (2 sync + edge + register).
//  Pulses never extend beyond 1 clk; rx_data held until next complete word.
//  Reset mid-frame: all outputs to reset values immediately; in-flight frame lost.
//   After release, IDLE waits for CS high before accepting a new frame (treated as ERR if low).
// TESTING
//  Mode 0, WIDTH=16, CS0, master sends 0xA55A, tx_data=0x1234
//   -> rx_valid once, rx_data=0xA55A, rx_ch=0, sdo shifts 0x1234 MSB first.
//  Modes 1,2,3 each, same words -> identical rx_data/sdo stream; first sdo bit valid before first sample edge.
//  Burst: CS1 low, 3 words 0x0001,0x8000,0xFFFF; tx_data updated on each tx_ready
//   -> 3 rx_valid pulses in order, rx_ch=1, 3 tx_ready, one frame_end, no abort.
//  Abort: CS0 rises after 7 bits -> abort=1 for 1 clk, frame_end=1, rx_valid never, rx_data unchanged.
//  Both CS low -> cs_err pulse, sdo=0, no rx_valid.
//   Release both then CS0 frame 0x00FF -> normal receive.
//  rst_n low after 8 bits -> all outputs 0.
//   Release with CS0 low -> no activity until CS0 high; next frame received correctly.
//  MSB_1ST=0, WIDTH=8: send 0x01 LSB first -> rx_data=0x01, sdo emits bit0 of tx_data first.

Source files
------------

// File: rtl/drv_spi_slave_mc_if.sv
// Pin-side and word-side signal bundle of the multi-channel SPI slave.
// The slave modport is the RTL view; the master modport is the MCU/register side.
interface drv_spi_slave_mc_if #(
  parameter int WIDTH = 16,
  parameter int N_CS  = 2,
  parameter int CH_W  = 3
);
  logic             spi_scl;
  logic             spi_sdi;
  logic             spi_sdo;
  logic [N_CS-1:0]  spi_cs_n;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [CH_W-1:0]  rx_ch;
  logic             frame_start;
  logic             frame_end;
  logic             abort;
  logic             cs_err;

  modport slave (
    input  spi_scl, spi_sdi, spi_cs_n, cfg_mode, tx_data,
    output spi_sdo, tx_ready, rx_data, rx_valid, rx_ch,
    output frame_start, frame_end, abort, cs_err
  );

  modport master (
    output spi_scl, spi_sdi, spi_cs_n, cfg_mode, tx_data,
    input  spi_sdo, tx_ready, rx_data, rx_valid, rx_ch,
    input  frame_start, frame_end, abort, cs_err
  );
endinterface

// File: rtl/drv_spi_slave_mc.sv
// Multi-channel SPI slave: oversampled SPI pins, runtime CPOL/CPHA, N chip selects,
// continuous multi-word bursts with per-word rx/tx handshakes and abort/error pulses.
module drv_spi_slave_mc #(
  parameter int WIDTH   = 16,
  parameter int N_CS    = 2,
  parameter int CH_W    = 3,
  parameter bit MSB_1ST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  drv_spi_slave_mc_if.slave        bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ERR
  } state_e;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_1ST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_1ST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return MSB_1ST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  // Synchronisers: [0],[1] metastability chain, scl_q[2] is the edge-detect history.
  logic [2:0]      scl_q;
  logic [1:0]      sdi_q;
  logic [N_CS-1:0] cs_meta_q;
  logic [N_CS-1:0] cs_q;

  state_e           state_q,       state_d;
  logic [1:0]       mode_q,        mode_d;
  logic             armed_q,       armed_d;
  logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
  logic [WIDTH-1:0] rx_sh_q,       rx_sh_d;
  logic [WIDTH-1:0] tx_sh_q,       tx_sh_d;
  logic             hold_q,        hold_d;
  logic             sdo_q,         sdo_d;
  logic [WIDTH-1:0] rx_data_q,     rx_data_d;
  logic [CH_W-1:0]  rx_ch_q,       rx_ch_d;
  logic             tx_ready_q,    tx_ready_d;
  logic             rx_valid_q,    rx_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q,   frame_end_d;
  logic             abort_q,       abort_d;
  logic             cs_err_q,      cs_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q     <= '0;
      sdi_q     <= '0;
      // NOTE: CS synchronisers reset to "asserted" so a chip select already low at
      // reset release is seen as a mid-frame select and never starts a frame.
      cs_meta_q <= '0;
      cs_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge value of its neighbour; blocking here would collapse the chain.
      scl_q     <= {scl_q[1:0], bus.spi_scl};
      sdi_q     <= {sdi_q[0], bus.spi_sdi};
      cs_meta_q <= bus.spi_cs_n;
      cs_q      <= cs_meta_q;
    end
  end

  logic scl_rise, scl_fall, cpol, cpha;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign scl_rise    = scl_q[1] & ~scl_q[2];
  assign scl_fall    = ~scl_q[1] & scl_q[2];
  assign cpol        = mode_q[1];
  assign cpha        = mode_q[0];
  assign lead_edge   = cpol ? scl_fall : scl_rise;
  assign trail_edge  = cpol ? scl_rise : scl_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  logic            any_low, multi_low, sel, all_high;
  logic [CH_W-1:0] chan;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    any_low   = 1'b0;
    multi_low = 1'b0;
    chan      = '0;
    for (int i = 0; i < N_CS; i++) begin
      if (!cs_q[i]) begin
        if (any_low) multi_low = 1'b1;
        else         chan      = CH_W'(i);
        any_low = 1'b1;
      end
    end
  end

  assign sel      = any_low & ~multi_low;
  assign all_high = &cs_q;

  logic [WIDTH-1:0] word_v;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    armed_d       = armed_q | all_high;
    bit_cnt_d     = bit_cnt_q;
    rx_sh_d       = rx_sh_q;
    tx_sh_d       = tx_sh_q;
    hold_d        = hold_q;
    sdo_d         = sdo_q;
    rx_data_d     = rx_data_q;
    rx_ch_d       = rx_ch_q;
    tx_ready_d    = 1'b0;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    abort_d       = 1'b0;
    cs_err_d      = 1'b0;
    word_v        = shift_in(rx_sh_q, sdi_q[1]);

    unique case (state_q)
      ST_IDLE: begin
        sdo_d  = 1'b0;
        mode_d = bus.cfg_mode;
        if (!armed_q) begin
          if (any_low) state_d = ST_ERR;
        end else if (sel) begin
          frame_start_d = 1'b1;
          rx_ch_d       = chan;
          bit_cnt_d     = '0;
          tx_sh_d       = bus.tx_data;
          tx_ready_d    = 1'b1;
          // CPHA=1 drives bit 0 on the first lead edge instead of here.
          hold_d        = bus.cfg_mode[0];
          sdo_d         = bus.cfg_mode[0] ? 1'b0 : head_bit(bus.tx_data);
          state_d       = ST_ACTIVE;
        end else if (any_low) begin
          cs_err_d = 1'b1;
          state_d  = ST_ERR;
        end
      end

      ST_ACTIVE: begin
        if (sample_edge) begin
          rx_sh_d = word_v;
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            rx_data_d  = word_v;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            tx_sh_d    = bus.tx_data;
            tx_ready_d = 1'b1;
            hold_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          if (hold_q) begin
            sdo_d  = head_bit(tx_sh_q);
            hold_d = 1'b0;
          end else begin
            tx_sh_d = advance(tx_sh_q);
            sdo_d   = head_bit(advance(tx_sh_q));
          end
        end
        // A word completing in the same clk as deselect leaves bit_cnt_d at 0: no abort.
        if (!(sel && (chan == rx_ch_q))) begin
          frame_end_d = 1'b1;
          abort_d     = (bit_cnt_d != '0);
          sdo_d       = 1'b0;
          state_d     = any_low ? ST_ERR : ST_IDLE;
        end
      end

      ST_ERR: begin
        sdo_d = 1'b0;
        if (all_high) state_d = ST_IDLE;
      end

      default: begin
        sdo_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= '0;
      armed_q       <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      hold_q        <= 1'b0;
      sdo_q         <= 1'b0;
      rx_data_q     <= '0;
      rx_ch_q       <= '0;
      tx_ready_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      abort_q       <= 1'b0;
      cs_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      hold_q        <= hold_d;
      sdo_q         <= sdo_d;
      rx_data_q     <= rx_data_d;
      rx_ch_q       <= rx_ch_d;
      tx_ready_q    <= tx_ready_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      abort_q       <= abort_d;
      cs_err_q      <= cs_err_d;
    end
  end

  assign bus.spi_sdo     = sdo_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_ch       = rx_ch_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.abort       = abort_q;
  assign bus.cs_err      = cs_err_q;

endmodule
